// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared widths, request/response types and the round-robin pick for ram_port_arbiter
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef DATA_DEPTH
`define DATA_DEPTH 256
`endif
package ram_arb_pkg;
    localparam int ARB_N_REQ     = 4;
    localparam int ARB_DW        = `DATA_WIDTH;
    localparam int ARB_AW        = $clog2(`DATA_DEPTH);
    localparam int ARB_RD_LAT    = 2;
    localparam int ARB_RSP_DEPTH = 4;
    localparam int ID_W          = $clog2(ARB_N_REQ);
    localparam int CNT_W         = $clog2(ARB_RSP_DEPTH + 1);

    typedef struct packed {
        logic              we;
        logic [ARB_AW-1:0] addr;
        logic [ARB_DW-1:0] wdata;
    } ram_req_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ARB_DW-1:0] data;
    } rsp_t;

    // one-hot of the first set bit of mask at or after ptr, wrapping
    function automatic logic [ARB_N_REQ-1:0] rr_pick(input logic [ARB_N_REQ-1:0] mask, input logic [ID_W-1:0] ptr);
        logic [ARB_N_REQ-1:0] g;
        logic [ID_W-1:0]      idx;
        g = '0;
        for (int k = ARB_N_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(ptr) + k) % ARB_N_REQ);
            if (mask[idx]) g = ARB_N_REQ'(1) << idx;
        end
        return g;
    endfunction
endpackage

// File: rtl/ram_arb_rsp_fifo.sv
// ram_arb_rsp_fifo: first-word-fall-through response FIFO with occupancy count
module ram_arb_rsp_fifo
    import ram_arb_pkg::*;
#(
    parameter int DEPTH = ARB_RSP_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [$bits(rsp_t)-1:0]    push_data,
    input  logic                       pop,
    output logic [$bits(rsp_t)-1:0]    pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    rsp_t          mem_q [DEPTH];
    rsp_t          mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_pop;

    always_comb begin
        do_pop = pop && cnt_q != '0;
        mem_d = mem_q;
        mem_d[wr_q] = push ? rsp_t'(push_data) : mem_q[wr_q];
        wr_d = wr_q + PW'(push);
        rd_d = rd_q + PW'(do_pop);
        cnt_d = cnt_q + CW'(push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) mem_q <= mem_d;

    always_ff @(posedge clk)
        if (rst_n) assert (!(push && !do_pop && cnt_q == CW'(DEPTH)));

    assign pop_data = mem_q[rd_q];
    assign empty    = cnt_q == '0;
    assign count    = cnt_q;
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: one RAM port shared by N_REQ requesters; round-robin with RAM_ARB_RR_EN, else fixed priority
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N_REQ     = ARB_N_REQ,
    parameter int DW        = ARB_DW,
    parameter int AW        = ARB_AW,
    parameter int RD_LAT    = ARB_RD_LAT,
    parameter int RSP_DEPTH = ARB_RSP_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ-1:0]         req_we,
    input  logic [N_REQ*AW-1:0]      req_addr,
    input  logic [N_REQ*DW-1:0]      req_wdata,
    output logic                     ram_we,
    output logic [AW-1:0]            ram_addr,
    output logic [DW-1:0]            ram_din,
    input  logic [DW-1:0]            ram_dout,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [DW-1:0]            rsp_data
);
    logic [N_REQ-1:0]          elig, gnt;
    logic [ID_W-1:0]           gnt_id, ptr_q, ptr_d;
    ram_req_t                  sel;
    logic                      xfer, rd_xfer, pop, fifo_empty;
    logic                      ram_we_q, ram_we_d;
    logic [AW-1:0]             ram_addr_q, ram_addr_d;
    logic [DW-1:0]             ram_din_q, ram_din_d;
    logic [RD_LAT:0]           pipe_vld_q, pipe_vld_d;
    logic [RD_LAT:0][ID_W-1:0] pipe_id_q, pipe_id_d;
    logic [CNT_W-1:0]          fifo_count, cred;
    rsp_t                      fifo_out;

    // credit counts reads still in the pipe plus parked responses; a same-cycle pop frees credit next cycle
    always_comb begin
        cred = CNT_W'($countones(pipe_vld_q)) + fifo_count;
        elig = req_valid & (req_we | {N_REQ{cred < CNT_W'(RSP_DEPTH)}});
        gnt = rst_n ? rr_pick(elig, ptr_q) : '0;
        gnt_id = '0;
        sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                gnt_id = ID_W'(i);
                sel = '{we: req_we[i], addr: req_addr[i*AW +: AW], wdata: req_wdata[i*DW +: DW]};
            end
        end
        xfer = |gnt;
        rd_xfer = xfer && !sel.we;
        pop = rsp_valid && rsp_ready;
        ram_we_d = xfer && sel.we;
        ram_addr_d = xfer ? sel.addr : ram_addr_q;
        ram_din_d = xfer ? sel.wdata : ram_din_q;
`ifdef RAM_ARB_RR_EN
        ptr_d = xfer ? ID_W'((int'(gnt_id) + 1) % N_REQ) : ptr_q;
`else
        ptr_d = '0;
`endif
        pipe_vld_d = {pipe_vld_q[RD_LAT-1:0], rd_xfer};
        pipe_id_d = {pipe_id_q[RD_LAT-1:0], gnt_id};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            pipe_vld_q <= '0;
            pipe_id_q  <= '0;
        end else begin
            ptr_q      <= ptr_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_id_q  <= pipe_id_d;
        end
    end

    ram_arb_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pipe_vld_q[RD_LAT]),
        .push_data ({pipe_id_q[RD_LAT], ram_dout}),
        .pop       (pop),
        .pop_data  (fifo_out),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign req_ready = gnt;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign rsp_valid = !fifo_empty;
    assign rsp_id    = fifo_out.id;
    assign rsp_data  = fifo_out.data;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: scoreboard bench with a RAM model and a transaction-level reference for ram_port_arbiter
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;
    localparam int N     = ARB_N_REQ;
    localparam int DW    = ARB_DW;
    localparam int AW    = ARB_AW;
    localparam int DEPTH = ARB_RSP_DEPTH;
    localparam int IW    = ID_W;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready, req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_din, ram_dout;
    logic            rsp_valid, rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [DW-1:0]   rsp_data;
    logic            preload;

    logic [DW-1:0]    ram   [2**AW];
    logic [DW-1:0]    mem_m [2**AW];
    logic [AW-1:0]    ram_rd_a;
    logic [IW+DW-1:0] exp_q [$];
    logic [IW+DW-1:0] e;
    logic [N-1:0]     eg, acc;
    int               n_cmp = 0, n_err = 0;
    int               out_cnt, ptr_m, gi, w, n_acc;
    logic             a_bit;

    always #5 clk = ~clk;

    ram_port_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    function automatic logic [DW-1:0] init_val(input int a);
        return (a == 16) ? DW'('hA5) : DW'(a * 7 + 3);
    endfunction

    // registered-address, registered-output RAM: two cycles from ram_addr to ram_dout
    always @(posedge clk) begin
        if (preload) for (int a = 0; a < 2**AW; a++) ram[a] <= init_val(a);
        else if (ram_we) ram[ram_addr] <= ram_din;
        ram_rd_a <= ram_addr;
        ram_dout <= ram[ram_rd_a];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = 1'b1;
        req_we[i] = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        tick();
        rst_n = 1'b1;
    endtask

    // reference: grants follow the arbitration rule, memory is updated in transfer order, reads queue their answer
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            out_cnt = 0;
            ptr_m = 0;
            acc = '0;
            if (preload) for (int a = 0; a < 2**AW; a++) mem_m[a] = init_val(a);
        end else begin
            eg = '0;
            for (int k = 0; k < N; k++) begin
                gi = (ptr_m + k) % N;
                if (eg == '0 && req_valid[gi] && (req_we[gi] || out_cnt < DEPTH)) eg[gi] = 1'b1;
            end
            check("grant", 32'(req_ready), 32'(eg));
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rsp_unexpected: got id %0d data %0h, expected no response", rsp_id, rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e[DW +: IW]));
                    check("rsp_data", 32'(rsp_data), 32'(e[DW-1:0]));
                    out_cnt--;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (eg[i]) begin
`ifdef RAM_ARB_RR_EN
                    ptr_m = (i + 1) % N;
`endif
                    if (req_we[i]) mem_m[req_addr[i*AW +: AW]] = req_wdata[i*DW +: DW];
                    else begin
                        exp_q.push_back({IW'(i), mem_m[req_addr[i*AW +: AW]]});
                        out_cnt++;
                    end
                end
            end
            acc = eg;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        preload = 1'b1;
        rst_n = 1'b0;
        req_valid = '1;
        req_we = '0;
        req_addr = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 1) preload = 1'b0;
            #2;
            check("rst_req_ready", 32'(req_ready), 0);
            check("rst_ram_we", 32'(ram_we), 0);
            check("rst_rsp_valid", 32'(rsp_valid), 0);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        tick();

        set_req(2, 1'b0, AW'('h10), '0);
        #2 check("rd_grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid[2] = 1'b0;
        #2 check("rd_ram_addr", 32'(ram_addr), 'h10);
        check("rd_ram_we", 32'(ram_we), 0);
        tick();
        #2 check("rd_t2_valid", 32'(rsp_valid), 0);
        tick();
        #2 check("rd_t3_valid", 32'(rsp_valid), 0);
        tick();
        #2 check("rd_t4_valid", 32'(rsp_valid), 1);
        check("rd_t4_id", 32'(rsp_id), 2);
        check("rd_t4_data", 32'(rsp_data), 'hA5);
        tick();
        tick();

        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(32 + i), DW'(64 + i));
        for (int k = 0; k < 8; k++) begin
`ifdef RAM_ARB_RR_EN
            #2 check("fair_grant", 32'(req_ready), 32'(1 << (k % N)));
`else
            #2 check("fair_grant", 32'(req_ready), 1);
`endif
            tick();
        end
        req_valid = '0;
        tick();

        rsp_ready = 1'b0;
        n_acc = 0;
        set_req(0, 1'b0, AW'(48), '0);
        for (int c = 0; c < 12; c++) begin
            #2 a_bit = req_ready[0];
            tick();
            if (a_bit) begin
                n_acc++;
                req_addr[0 +: AW] = AW'(48 + n_acc);
            end
        end
        #2 check("bp_accepted", 32'(n_acc), 4);
        check("bp_ready0_low", 32'(req_ready[0]), 0);
        tick();
        set_req(1, 1'b1, AW'(5), DW'('h3C));
        #2 check("wb_grant", 32'(req_ready), 32'b0010);
        tick();
        req_valid[1] = 1'b0;
        #2 check("wb_ram_we", 32'(ram_we), 1);
        check("wb_ram_addr", 32'(ram_addr), 5);
        check("wb_ram_din", 32'(ram_din), 'h3C);
        tick();
        rsp_ready = 1'b1;
        for (int c = 0; c < 30 && n_acc < 6; c++) begin
            #2 a_bit = req_ready[0];
            tick();
            if (a_bit) begin
                n_acc++;
                if (n_acc < 6) req_addr[0 +: AW] = AW'(48 + n_acc);
                else req_valid[0] = 1'b0;
            end
        end
        check("bp_total", 32'(n_acc), 6);
        req_valid = '0;
        repeat (8) tick();

        set_req(0, 1'b1, AW'(7), DW'('h77));
        #2 check("wtr_w_grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid[0] = 1'b0;
        set_req(1, 1'b0, AW'(7), '0);
        #2 check("wtr_r_grant", 32'(req_ready), 32'b0010);
        tick();
        req_valid[1] = 1'b0;
        #2 w = 0;
        while (!rsp_valid && w < 10) begin
            tick();
            #2 w++;
        end
        check("wtr_valid", 32'(rsp_valid), 1);
        check("wtr_id", 32'(rsp_id), 1);
        check("wtr_data", 32'(rsp_data), 'h77);
        tick();

        for (int c = 0; c < 900; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    if ($urandom_range(0, 99) < 50)
                        set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
                    else req_valid[i] = 1'b0;
                end
            end
            rsp_ready = $urandom_range(0, 99) < 70;
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        #2 w = 0;
        while ((exp_q.size() != 0 || rsp_valid) && w < 40) begin
            tick();
            #2 w++;
        end
        check("drain_left", 32'(exp_q.size()), 0);
        check("drain_valid", 32'(rsp_valid), 0);
        tick();

        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    if ($urandom_range(0, 99) < 70) set_req(i, 1'b0, AW'($urandom_range(0, 15)), '0);
                    else req_valid[i] = 1'b0;
                end
            end
            rsp_ready = $urandom_range(0, 99) < 30;
            tick();
        end
        do_reset();
        rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #2 check("post_rst_rsp_valid", 32'(rsp_valid), 0);
            check("post_rst_ram_we", 32'(ram_we), 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
